load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges RV32I load/store requests from a CPU onto a single-port,
// word-organised data RAM with a one-cycle registered read.
//   - Loads  : IDLE -> READ -> WAIT -> RESP
//   - SW     : IDLE -> WRITE -> RESP
//   - SB/SH  : IDLE -> READ -> WAIT -> WRITE -> RESP (read-modify-write)
//   - Errors : IDLE -> RESP (misaligned access or illegal funct3)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32I width/sign selector
//   req_addr, req_wdata    byte address, right-aligned store data
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_err     extended load data, error flag
//   data_memory_address    RAM word address (req_addr[ADDR_W+1:2])
//   data_memory_data_in    full word written to RAM
//   store, load            RAM write / read strobes
//   data_memory_data_out   RAM read word, valid the cycle after load
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] data_memory_address,
    output logic [31:0]       data_memory_data_in,
    output logic              store,
    output logic              load,
    input  logic [31:0]       data_memory_data_out
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        req_err;
    logic        unused_addr_bits;

    // Address bits above the RAM word address alias onto the same words.
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == IDLE);

    // Pick the addressed byte/halfword out of a RAM word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the new byte (SB) or halfword (SH) onto the old RAM word.
    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic        half,
                                          input logic [1:0]  lane,
                                          input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (half) begin
            if (lane[1]) r[31:16] = wd;
            else         r[15:0]  = wd;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    // Error check on the incoming request: illegal width codes first,
    // then natural-alignment rules for halfword and word accesses.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = req_addr[0];
                3'b010:  req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = req_addr[0];
                3'b010:         req_err = |req_addr[1:0];
                default:        req_err = 1'b1;
            endcase
        end
    end

    // Single FSM; strobes and response fields are registered and
    // default to zero, so each is high only in the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            we_q                <= 1'b0;
            funct3_q            <= 3'd0;
            lane_q              <= 2'd0;
            wdata_q             <= 16'd0;
            load                <= 1'b0;
            store               <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_err             <= 1'b0;
            rsp_rdata           <= 32'd0;
            data_memory_address <= '0;
            data_memory_data_in <= 32'd0;
        end else begin
            load      <= 1'b0;
            store     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q                <= req_we;
                        funct3_q            <= req_funct3;
                        lane_q              <= req_addr[1:0];
                        wdata_q             <= req_wdata[15:0];
                        data_memory_address <= req_addr[ADDR_W+1:2];
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            state               <= WRITE;
                            store               <= 1'b1;
                            data_memory_data_in <= req_wdata;
                        end else begin
                            state <= READ;
                            load  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM word is on data_memory_data_out this cycle.
                    if (we_q) begin
                        state               <= WRITE;
                        store               <= 1'b1;
                        data_memory_data_in <= merge(data_memory_data_out,
                                                     funct3_q[0], lane_q, wdata_q);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extract(data_memory_data_out, funct3_q, lane_q);
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives directed load/store requests into load_store_unit connected to a
// small registered-read RAM. A transaction-level model predicts, at each
// accepted request, the response timing/data and the RAM strobes; a compare
// process checks the DUT against it every cycle. Literal expectations pin
// the model on known data patterns.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] data_memory_address;
    logic [31:0]   data_memory_data_in;
    logic          store;
    logic          load;
    logic [31:0]   data_memory_data_out;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_we               (req_we),
        .req_funct3           (req_funct3),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .rsp_valid            (rsp_valid),
        .rsp_rdata            (rsp_rdata),
        .rsp_err              (rsp_err),
        .data_memory_address  (data_memory_address),
        .data_memory_data_in  (data_memory_data_in),
        .store                (store),
        .load                 (load),
        .data_memory_data_out (data_memory_data_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, "_load"}, 32'(load), 32'd0);
        checkOutput({tag, "_store"}, 32'(store), 32'd0);
        checkOutput({tag, "_addr"}, 32'(data_memory_address), 32'd0);
        checkOutput({tag, "_wdata"}, data_memory_data_in, 32'd0);
    endtask

    // RAM: write on the edge where store is high, registered read.
    bit [31:0] mem [0:4095];
    bit        preloaded = 1'b0;
    logic [31:0] rd_q = 32'd0;
    assign data_memory_data_out = rd_q;

    always @(posedge clk) begin
        if (!preloaded) begin
            mem[0]    <= 32'h0BAD_F00D;
            mem[1023] <= 32'hCAFE_F00D;
            preloaded <= 1'b1;
        end
        if (store) mem[data_memory_address] <= data_memory_data_in;
        if (load)  rd_q <= mem[data_memory_address];
    end

    // Transaction-level model. Edge numbers count rising clock edges; an
    // expectation at edge e refers to the cycle right after that edge.
    bit [31:0]   ref_mem [0:4095];
    bit          ref_init = 1'b0;
    int          cyc = 0;
    bit          pend = 1'b0;
    int          e_rsp, e_ld, e_st, e_waddr;
    bit          e_err, e_wr;
    logic [31:0] e_rdata, e_wword;
    int          acc_count = 0;
    int          last_acc_edge = 0;

    always @(posedge clk) begin : model
        logic [31:0] a, w, mask, val;
        int          nb, sh;
        logic        il, mis;
        cyc++;
        if (!ref_init) begin
            ref_mem[0]    = 32'h0BAD_F00D;
            ref_mem[1023] = 32'hCAFE_F00D;
            ref_init      = 1'b1;
        end
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc > e_rsp) begin
                if (e_wr) ref_mem[e_waddr] = e_wword;
                pend = 1'b0;
            end
            if (req_valid && req_ready) begin
                a       = req_addr;
                e_waddr = int'((a >> 2) % 4096);
                nb      = 1 << req_funct3[1:0];
                sh      = 8 * int'(a % 4);
                il      = (req_funct3[1:0] == 2'd3) ||
                          (req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'b110));
                mis     = (a % 32'(nb)) != 0;
                mask    = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
                w       = ref_mem[e_waddr];
                e_err   = il || mis;
                e_wr    = req_we && !e_err;
                e_ld    = -1;
                e_st    = -1;
                e_rdata = 32'd0;
                e_wword = 32'd0;
                if (e_err) begin
                    e_rsp = cyc;
                end else if (!req_we) begin
                    val = (w >> sh) & mask;
                    if (!req_funct3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
                    e_rdata = val;
                    e_ld    = cyc;
                    e_rsp   = cyc + 2;
                end else if (nb == 4) begin
                    e_wword = req_wdata;
                    e_st    = cyc;
                    e_rsp   = cyc + 1;
                end else begin
                    e_wword = (w & ~(mask << sh)) | ((req_wdata & mask) << sh);
                    e_ld    = cyc;
                    e_st    = cyc + 2;
                    e_rsp   = cyc + 3;
                end
                pend          = 1'b1;
                acc_count++;
                last_acc_edge = cyc;
            end
        end
    end

    // Per-cycle compare against the model, plus a log of observed events.
    int          rsp_count = 0;
    int          load_cnt = 0;
    int          store_cnt = 0;
    int          last_rsp_edge = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    logic [31:0] last_store_data = 32'd0;
    logic [31:0] last_store_addr = 32'd0;
    int          rsp_log[$];
    bit          x_valid, x_load, x_store;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            checkResetOutputs("rst_cyc");
        end else begin
            x_valid = pend && (cyc == e_rsp);
            x_load  = pend && (cyc == e_ld);
            x_store = pend && (cyc == e_st);
            checkOutput("cyc_ready", 32'(req_ready), 32'(!pend));
            checkOutput("cyc_rsp_valid", 32'(rsp_valid), 32'(x_valid));
            checkOutput("cyc_rsp_err", 32'(rsp_err), 32'(x_valid && e_err));
            checkOutput("cyc_load", 32'(load), 32'(x_load));
            checkOutput("cyc_store", 32'(store), 32'(x_store));
            if (x_valid) checkOutput("cyc_rsp_rdata", rsp_rdata, e_rdata);
            if (pend && !e_err) checkOutput("cyc_addr", 32'(data_memory_address), 32'(e_waddr));
            if (x_store) checkOutput("cyc_wdata", data_memory_data_in, e_wword);
        end
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_edge = cyc;
            last_rdata    = rsp_rdata;
            last_err      = rsp_err;
            rsp_log.push_back(cyc);
        end
        if (load) load_cnt++;
        if (store) begin
            store_cnt++;
            last_store_data = data_memory_data_in;
            last_store_addr = 32'(data_memory_address);
        end
    end

    task automatic waitAccept(input int target);
        int n = 0;
        while (acc_count < target && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_seen", 32'(acc_count >= target), 32'd1);
    endtask

    task automatic waitRsp(input int target);
        int n = 0;
        while (rsp_count < target && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_seen", 32'(rsp_count >= target), 32'd1);
    endtask

    // One complete request: present it, drop valid after acceptance, wait
    // for the response.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int a0 = acc_count;
        int r0 = rsp_count;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        waitAccept(a0 + 1);
        req_valid = 1'b0;
        waitRsp(r0 + 1);
    endtask

    task automatic expectRsp(input string name, input logic [31:0] rdata,
                             input logic err, input int lat);
        checkOutput({name, "_rdata"}, last_rdata, rdata);
        checkOutput({name, "_err"}, 32'(last_err), 32'(err));
        checkOutput({name, "_lat"}, 32'(last_rsp_edge - last_acc_edge), 32'(lat));
    endtask

    int l0, s0, r0, a0;
    int acc_e[3];

    initial begin
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("rst_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // SW then loads of every width from the same word.
        applyStimulus(1'b1, 3'b010, 32'h0000_01EC, 32'h1234_CDEF);
        expectRsp("sw", 32'd0, 1'b0, 1);
        checkOutput("sw_store_addr", last_store_addr, 32'd123);
        checkOutput("sw_store_data", last_store_data, 32'h1234_CDEF);
        applyStimulus(1'b0, 3'b000, 32'h0000_01ED, 32'd0);
        expectRsp("lb", 32'hFFFF_FFCD, 1'b0, 2);
        applyStimulus(1'b0, 3'b100, 32'h0000_01ED, 32'd0);
        expectRsp("lbu", 32'h0000_00CD, 1'b0, 2);
        applyStimulus(1'b0, 3'b001, 32'h0000_01EE, 32'd0);
        expectRsp("lh_hi", 32'h0000_1234, 1'b0, 2);
        applyStimulus(1'b0, 3'b001, 32'h0000_01EC, 32'd0);
        expectRsp("lh_lo", 32'hFFFF_CDEF, 1'b0, 2);
        applyStimulus(1'b0, 3'b101, 32'h0000_01EC, 32'd0);
        expectRsp("lhu", 32'h0000_CDEF, 1'b0, 2);

        // Read-modify-write stores.
        applyStimulus(1'b1, 3'b000, 32'h0000_01EF, 32'h0000_00AB);
        expectRsp("sb", 32'd0, 1'b0, 3);
        checkOutput("sb_store_data", last_store_data, 32'hAB34_CDEF);
        applyStimulus(1'b0, 3'b010, 32'h0000_01EC, 32'd0);
        expectRsp("lw_after_sb", 32'hAB34_CDEF, 1'b0, 2);
        applyStimulus(1'b1, 3'b001, 32'h0000_01EC, 32'h5555_7777);
        checkOutput("sh_store_data", last_store_data, 32'hAB34_7777);
        applyStimulus(1'b0, 3'b010, 32'h0010_01EC, 32'd0);
        expectRsp("lw_alias", 32'hAB34_7777, 1'b0, 2);

        // Error cases: no strobes, immediate response.
        l0 = load_cnt;
        s0 = store_cnt;
        applyStimulus(1'b0, 3'b010, 32'h0000_3FFE, 32'd0);
        expectRsp("lw_mis", 32'd0, 1'b1, 0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF);
        expectRsp("sh_mis", 32'd0, 1'b1, 0);
        applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'd0);
        expectRsp("ld_f3_011", 32'd0, 1'b1, 0);
        applyStimulus(1'b1, 3'b100, 32'h0000_0000, 32'd0);
        expectRsp("st_f3_100", 32'd0, 1'b1, 0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0FFF, 32'h0000_1111);
        expectRsp("sh_fff", 32'd0, 1'b1, 0);
        checkOutput("err_no_load", 32'(load_cnt - l0), 32'd0);
        checkOutput("err_no_store", 32'(store_cnt - s0), 32'd0);

        // SH abandoned by reset while waiting on the RAM read.
        s0 = store_cnt;
        r0 = rsp_count;
        a0 = acc_count;
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h0000_0FFE;
        req_wdata  = 32'h0000_2222;
        req_valid  = 1'b1;
        waitAccept(a0 + 1);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkResetOutputs("rst_wait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abandon_no_store", 32'(store_cnt - s0), 32'd0);
        checkOutput("abandon_no_rsp", 32'(rsp_count - r0), 32'd0);
        checkOutput("abandon_ram", mem[1023], 32'hCAFE_F00D);
        applyStimulus(1'b0, 3'b010, 32'h0000_0FFC, 32'd0);
        expectRsp("lw_after_abandon", 32'hCAFE_F00D, 1'b0, 2);

        // Three LW with req_valid held high throughout.
        r0 = rsp_count;
        a0 = acc_count;
        @(negedge clk);
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_01EC;
        req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitAccept(a0 + k + 1);
            acc_e[k] = last_acc_edge;
            if (k == 0)      req_addr = 32'h0000_0FFC;
            else if (k == 1) req_addr = 32'h0000_0000;
            else             req_valid = 1'b0;
        end
        waitRsp(r0 + 3);
        checkOutput("b2b_rsps", 32'(rsp_count - r0), 32'd3);
        expectRsp("b2b_last", 32'h0BAD_F00D, 1'b0, 2);
        for (int k = 1; k < 3; k++) begin
            if (rsp_count - r0 >= k)
                checkOutput("b2b_gap", 32'(acc_e[k] - rsp_log[r0 + k - 1]), 32'd2);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
